// File: rtl/mmio_store_port_pkg.sv
// Shared register map for the MMIO store port: word offsets inside the
// 16-byte window and CTRL bit positions.
package mmio_pkg;

    typedef enum logic [1:0] {
        OFF_DATA   = 2'd0,
        OFF_CTRL   = 2'd1,
        OFF_STATUS = 2'd2,
        OFF_DROPS  = 2'd3
    } reg_off_t;

    localparam int CTRL_FLUSH = 0;
    localparam int CTRL_IE    = 1;

endpackage

// File: rtl/mmio_store_port_if.sv
// Processor data-port signals plus the outgoing valid/ready word stream.
// slave is the responder side, master is the processor/consumer side.
interface mmio_store_port_if;

    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        hit;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        irq;

    modport slave (
        input  MemWrite, DataAdr, WriteData, out_ready,
        output ReadData, hit, out_valid, out_data, irq
    );

    modport master (
        output MemWrite, DataAdr, WriteData, out_ready,
        input  ReadData, hit, out_valid, out_data, irq
    );

endinterface

// File: rtl/mmio_store_port_sync_fifo.sv
// First-word fall-through FIFO. A push into a full FIFO is only accepted
// when a pop frees the slot on the same edge; flush beats both push and pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop) && !flush;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mmio_store_port.sv
// Memory-mapped store port: decodes a 16-byte window on the processor data
// port, queues DATA writes into a FIFO and streams them to a consumer.
module mmio_store_port
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter int          DEPTH     = 8
) (
    input  logic             clk,
    input  logic             reset,
    mmio_store_port_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    reg_off_t        off;
    logic            write_en;
    logic            push;
    logic            pop;
    logic            flush;
    logic            ctrl_wr;
    logic            drops_wr;
    logic            drop_evt;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic [31:0]     head;
    logic            ie;
    logic [15:0]     drops;
    logic [7:0]      count_ext;
    logic            unused_byte_bits;

    assign bus.hit   = (bus.DataAdr[31:4] == BASE_ADDR[31:4]);
    assign off       = reg_off_t'(bus.DataAdr[3:2]);
    assign unused_byte_bits = &{1'b0, bus.DataAdr[1:0]};

    assign write_en  = bus.MemWrite && bus.hit;
    assign push      = write_en && (off == OFF_DATA);
    assign ctrl_wr   = write_en && (off == OFF_CTRL);
    assign drops_wr  = write_en && (off == OFF_DROPS);
    assign flush     = ctrl_wr && bus.WriteData[CTRL_FLUSH];
    assign pop       = bus.out_valid && bus.out_ready;
    assign drop_evt  = push && full && !pop;
    assign count_ext = 8'(count);

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (bus.WriteData),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign bus.out_valid = !empty;
    assign bus.out_data  = head;
    assign bus.irq       = ie && !empty;

    // Interrupt enable follows every CTRL write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie <= 1'b0;
        end else if (ctrl_wr) begin
            ie <= bus.WriteData[CTRL_IE];
        end
    end

    // Saturating drop counter; a DROPS write clears it even if a drop lands on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drops <= '0;
        end else if (drops_wr) begin
            drops <= '0;
        end else if (drop_evt && (drops != 16'hFFFF)) begin
            drops <= drops + 16'd1;
        end
    end

    // Register read mux; FLUSH is write-only so CTRL bit0 always reads 0.
    always_comb begin
        bus.ReadData = '0;
        if (bus.hit) begin
            case (off)
                OFF_DATA:   bus.ReadData = head;
                OFF_CTRL:   bus.ReadData = {30'b0, ie, 1'b0};
                OFF_STATUS: bus.ReadData = {16'b0, count_ext, 6'b0, full, empty};
                OFF_DROPS:  bus.ReadData = {16'b0, drops};
                default:    bus.ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_store_port.sv
module tb_mmio_store_port;

    localparam logic [31:0] BASE  = 32'h0000_0400;
    localparam int          DEPTH = 8;

    logic clk;
    logic reset;
    mmio_store_port_if bus();

    mmio_store_port #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] exp_q[$];
    logic        m_ie;
    logic [15:0] m_drops;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] adr);
        int n;
        n = exp_q.size();
        if ((adr >> 4) != (BASE >> 4)) return 32'h0;
        case (adr[3:2])
            2'd0: return (n != 0) ? exp_q[0] : 32'h0;
            2'd1: return {30'b0, m_ie, 1'b0};
            2'd2: return (32'(n) << 8) | ((n == DEPTH) ? 32'h2 : 32'h0) | ((n == 0) ? 32'h1 : 32'h0);
            default: return {16'b0, m_drops};
        endcase
    endfunction

    // One bus cycle: drive, check combinational outputs, take the edge, update the model.
    task automatic cycle(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic rdy);
        bit h;
        int pre;
        bit popped;
        bus.MemWrite  = we;
        bus.DataAdr   = adr;
        bus.WriteData = wd;
        bus.out_ready = rdy;
        h = ((adr >> 4) == (BASE >> 4));
        #1;
        chk("hit", {31'b0, bus.hit}, {31'b0, h});
        if (!we) chk("read_data", bus.ReadData, exp_read(adr));
        pre = exp_q.size();
        popped = rdy && (pre > 0);
        @(posedge clk);
        #1;
        if (we && h) begin
            case (adr[3:2])
                2'd0: begin
                    if (pre < DEPTH || popped) exp_q.push_back(wd);
                    else if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                end
                2'd1: begin
                    m_ie = wd[1];
                    if (wd[0]) exp_q.delete();
                end
                2'd3: m_drops = 16'h0;
                default: ;
            endcase
        end
    endtask

    task automatic rd(input logic [31:0] adr);
        cycle(1'b0, adr, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        m_ie = 1'b0;
        m_drops = 16'h0;
        bus.MemWrite = 1'b0;
        bus.out_ready = 1'b0;
        bus.DataAdr = BASE + 32'h8;
        #1;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_irq", {31'b0, bus.irq}, 32'h0);
        chk("rst_status", bus.ReadData, 32'h0000_0001);
        bus.DataAdr = BASE + 32'hC;
        #1;
        chk("rst_drops", bus.ReadData, 32'h0);
        bus.DataAdr = BASE + 32'h4;
        #1;
        chk("rst_ctrl", bus.ReadData, 32'h0);
        bus.DataAdr = BASE;
        #1;
        chk("rst_data", bus.ReadData, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Stream scoreboard: compares every accepted head against the model queue.
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_q.size() != 0});
            chk("irq", {31'b0, bus.irq}, {31'b0, m_ie && exp_q.size() != 0});
            if (!bus.out_valid) chk("out_data_idle", bus.out_data, 32'h0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_pop", bus.out_data, 32'hxxxx_xxxx);
                else chk("out_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        int          sel;

        bus.MemWrite = 1'b0;
        bus.DataAdr = 32'h0;
        bus.WriteData = 32'h0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        m_ie = 1'b0;
        m_drops = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // two words, consumer stalled, then drained
        cycle(1'b1, BASE, 32'hA5, 1'b0);
        cycle(1'b1, BASE, 32'h5A, 1'b0);
        rd(BASE + 32'h8);
        chk("status_two", exp_read(BASE + 32'h8), 32'h0000_0200);
        chk("head_a5", bus.out_data, 32'hA5);
        cycle(1'b0, BASE + 32'h8, 32'h0, 1'b1);
        cycle(1'b0, BASE + 32'h8, 32'h0, 1'b1);
        chk("drained", {31'b0, bus.out_valid}, 32'h0);

        // overflow by two
        for (int i = 0; i < 10; i++) cycle(1'b1, BASE, 32'h100 + 32'(i), 1'b0);
        rd(BASE + 32'h8);
        chk("status_full", exp_read(BASE + 32'h8), 32'h0000_0802);
        rd(BASE + 32'hC);
        chk("drops_two", {16'b0, m_drops}, 32'h2);
        cycle(1'b1, BASE + 32'hC, 32'h0, 1'b0);
        rd(BASE + 32'hC);

        // push into full FIFO while popping
        cycle(1'b1, BASE, 32'hBEEF, 1'b1);
        rd(BASE + 32'h8);
        rd(BASE + 32'hC);
        for (int i = 0; i < 8; i++) cycle(1'b0, BASE + 32'h8, 32'h0, 1'b1);
        rd(BASE + 32'h8);

        // interrupt enable, then flush racing a pop
        cycle(1'b1, BASE + 32'h4, 32'h2, 1'b0);
        cycle(1'b1, BASE, 32'h77, 1'b0);
        chk("irq_set", {31'b0, bus.irq}, 32'h1);
        cycle(1'b1, BASE + 32'h4, 32'h3, 1'b1);
        rd(BASE + 32'h4);
        chk("ctrl_ie", bus.ReadData, 32'h2);
        rd(BASE + 32'h8);

        // out-of-window store, byte offset ignored on load
        cycle(1'b1, 32'h0000_0500, 32'h1234, 1'b0);
        rd(BASE + 32'hF);
        rd(32'h0000_0500);

        // reset with words queued
        for (int i = 0; i < 3; i++) cycle(1'b1, BASE, 32'hC0 + 32'(i), 1'b0);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            sel = $urandom_range(0, 99);
            we = ($urandom_range(0, 1) == 1);
            if (sel < 10) adr = $urandom;
            else adr = BASE | 32'($urandom_range(0, 15));
            wd = $urandom;
            if ((adr >> 4) == (BASE >> 4) && adr[3:2] == 2'd1 && $urandom_range(0, 7) != 0) wd[0] = 1'b0;
            cycle(we, adr, wd, ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
